// File: rtl/mem_arbiter.sv
// Two-port I/D memory arbiter with ownership hold and round-robin ties.
// Define MEM_ARBITER_DCACHE_PRIORITY_EN to make every tie go to the D port.
package mem_arbiter_pkg;
  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } mem_op_e;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  input  mem_op_e           i_req_operation,
  input  logic [ADDR_W-1:0] i_req_address,
  input  logic [DATA_W-1:0] i_req_store_word,
  output logic [DATA_W-1:0] i_req_loaded_word,
  output logic              i_req_fulfilled,
  input  logic              d_req_valid,
  input  mem_op_e           d_req_operation,
  input  logic [ADDR_W-1:0] d_req_address,
  input  logic [DATA_W-1:0] d_req_store_word,
  output logic [DATA_W-1:0] d_req_loaded_word,
  output logic              d_req_fulfilled,
  output logic              m_req_valid,
  output mem_op_e           m_req_operation,
  output logic [ADDR_W-1:0] m_req_address,
  output logic [DATA_W-1:0] m_req_store_word,
  input  logic [DATA_W-1:0] m_req_loaded_word,
  input  logic              m_req_fulfilled,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_I = 2'd1,
    ST_OWN_D = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   tie_to_d;

`ifdef MEM_ARBITER_DCACHE_PRIORITY_EN
  assign tie_to_d = 1'b1;
`else
  logic last_d_q;

  assign tie_to_d = ~last_d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_d_q <= 1'b1;
    end else if (state_d == ST_OWN_I) begin
      last_d_q <= 1'b0;
    end else if (state_d == ST_OWN_D) begin
      last_d_q <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        unique case (1'b1)
          i_req_valid && d_req_valid:
            state_d = tie_to_d ? ST_OWN_D : ST_OWN_I;
          i_req_valid && !d_req_valid:
            state_d = ST_OWN_I;
          !i_req_valid && d_req_valid:
            state_d = ST_OWN_D;
          default:
            state_d = ST_IDLE;
        endcase
      end
      ST_OWN_I: begin
        if (i_req_valid)      state_d = ST_OWN_I;
        else if (d_req_valid) state_d = ST_OWN_D;
        else                  state_d = ST_IDLE;
      end
      ST_OWN_D: begin
        if (d_req_valid)      state_d = ST_OWN_D;
        else if (i_req_valid) state_d = ST_OWN_I;
        else                  state_d = ST_IDLE;
      end
      default: state_d = state_e'(2'bxx);
    endcase
  end

  always_comb begin
    m_req_valid       = 1'b0;
    m_req_operation   = OP_LOAD;
    m_req_address     = '0;
    m_req_store_word  = '0;
    i_req_loaded_word = '0;
    i_req_fulfilled   = 1'b0;
    d_req_loaded_word = '0;
    d_req_fulfilled   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
      end
      ST_OWN_I: begin
        m_req_valid       = i_req_valid;
        m_req_operation   = i_req_operation;
        m_req_address     = i_req_address;
        m_req_store_word  = i_req_store_word;
        i_req_loaded_word = m_req_loaded_word;
        i_req_fulfilled   = m_req_fulfilled;
      end
      ST_OWN_D: begin
        m_req_valid       = d_req_valid;
        m_req_operation   = d_req_operation;
        m_req_address     = d_req_address;
        m_req_store_word  = d_req_store_word;
        d_req_loaded_word = m_req_loaded_word;
        d_req_fulfilled   = m_req_fulfilled;
      end
      default: begin
        m_req_valid       = 1'bx;
        m_req_operation   = mem_op_e'(1'bx);
        m_req_address     = 'x;
        m_req_store_word  = 'x;
        i_req_loaded_word = 'x;
        i_req_fulfilled   = 1'bx;
        d_req_loaded_word = 'x;
        d_req_fulfilled   = 1'bx;
      end
    endcase
  end

  // grant tracks state exactly because it is loaded from the same next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant <= 2'b00;
    end else begin
      unique case (state_d)
        ST_IDLE:  grant <= 2'b00;
        ST_OWN_I: grant <= 2'b01;
        ST_OWN_D: grant <= 2'b10;
        default:  grant <= 2'bxx;
      endcase
    end
  end

endmodule
